// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer: state encoding, default widths and
// small decode helpers for the three enable lines.
package phase_timer_pkg;

  localparam int DEFAULT_CW = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACC  = 3'd1;
  localparam logic [2:0] ST_LINE = 3'd2;
  localparam logic [2:0] ST_GEAR = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_ACC  = ST_ACC,
    S_LINE = ST_LINE,
    S_GEAR = ST_GEAR,
    S_DONE = ST_DONE
  } state_e;

  // Enable vector ordering is {gear, line, acc}.
  function automatic logic is_multi(input logic [2:0] en);
    return (en[0] & en[1]) | (en[0] & en[2]) | (en[1] & en[2]);
  endfunction

  function automatic state_e phase_for(input logic [2:0] en);
    case (en)
      3'b001:  return S_ACC;
      3'b010:  return S_LINE;
      3'b100:  return S_GEAR;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer_if.sv
// Control/status bundle between the clamp controller (master) and the phase
// timer (slave).
interface phase_timer_if #(
  parameter int CW = phase_timer_pkg::DEFAULT_CW
);

  logic          en_acc;
  logic          en_line_timer;
  logic          en_gear_timer;
  logic [CW-1:0] acc_len;
  logic [CW-1:0] line_len;
  logic [CW-1:0] gear_len;
  logic          ready;
  logic          line_end;
  logic          gear_end;
  logic          busy;
  logic          err;

  modport master (
    output en_acc, en_line_timer, en_gear_timer, acc_len, line_len, gear_len,
    input  ready, line_end, gear_end, busy, err
  );

  modport slave (
    input  en_acc, en_line_timer, en_gear_timer, acc_len, line_len, gear_len,
    output ready, line_end, gear_end, busy, err
  );

endinterface

// File: rtl/phase_timer_tick_gen.sv
// Prescaler for the phase timer: emits a one-cycle tick every PRESCALE
// enabled clock cycles, restartable from zero via clear.
module tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] TOP = 16'(PRESCALE - 1);

  logic [15:0] count_q, count_d;

  assign tick = en && (count_q == TOP);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == TOP) ? '0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Phase timer: times the accumulate, line and gear phases of the clamp
// sequence in prescaled ticks and reports completion with one-cycle pulses.
import phase_timer_pkg::*;

module phase_timer #(
  parameter int PRESCALE = 1000,
  parameter int CW       = DEFAULT_CW
) (
  input  logic         clk,
  input  logic         resetn,
  phase_timer_if.slave bus
);

  state_e        state_q, state_d;
  state_e        cur_q, cur_d;
  state_e        start_phase;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] start_len;
  logic          ready_q, ready_d;
  logic          line_end_q, line_end_d;
  logic          gear_end_q, gear_end_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [2:0]    en;
  logic          multi, sel, cur_en, in_phase, start, tick;

  assign en       = {bus.en_gear_timer, bus.en_line_timer, bus.en_acc};
  assign multi    = is_multi(en);
  assign sel      = (|en) && !multi;
  assign in_phase = (state_q == S_ACC) || (state_q == S_LINE) || (state_q == S_GEAR);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .clear  (start),
    .en     (in_phase),
    .tick   (tick)
  );

  always_comb begin
    start_phase = phase_for(en);
    case (start_phase)
      S_ACC:   start_len = bus.acc_len;
      S_LINE:  start_len = bus.line_len;
      S_GEAR:  start_len = bus.gear_len;
      default: start_len = '0;
    endcase
    case (cur_q)
      S_ACC:   cur_en = en[0];
      S_LINE:  cur_en = en[1];
      S_GEAR:  cur_en = en[2];
      default: cur_en = 1'b0;
    endcase
  end

  // Once err is set the block stays parked in IDLE until reset.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ready_d    = 1'b0;
    line_end_d = 1'b0;
    gear_end_d = 1'b0;
    start      = 1'b0;

    if (multi || err_q) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel) start = 1'b1;
        end
        S_ACC, S_LINE, S_GEAR: begin
          if (!cur_en) begin
            state_d = S_IDLE;
          end else if (cnt_q == len_q) begin
            state_d    = S_DONE;
            ready_d    = (state_q == S_ACC);
            line_end_d = (state_q == S_LINE);
            gear_end_d = (state_q == S_GEAR);
          end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (!cur_en) begin
            if (sel) start = 1'b1;
            else     state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (start) begin
      state_d = start_phase;
      cur_d   = start_phase;
      len_d   = start_len;
      cnt_d   = '0;
    end

    busy_d = (state_d == S_ACC) || (state_d == S_LINE) || (state_d == S_GEAR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cur_q      <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      line_end_q <= 1'b0;
      gear_end_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      line_end_q <= line_end_d;
      gear_end_q <= gear_end_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.line_end = line_end_q;
  assign bus.gear_end = gear_end_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: expected pulses (kind and arrival cycle) are
// queued when a phase is started and matched by a negedge monitor.
module tb_phase_timer;

  localparam int P  = 4;
  localparam int CW = 16;

  typedef struct {
    logic [2:0] kind;
    int         cycle;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t expQ[$];
  exp_t e;
  logic [2:0] p;

  phase_timer_if #(.CW(CW)) bus ();

  phase_timer #(.PRESCALE(P), .CW(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse kind encoding matches {gear_end, line_end, ready}.
  task automatic applyStimulus(input logic a, input logic l, input logic g, input logic [2:0] kind, input int latency);
    bus.en_acc        = a;
    bus.en_line_timer = l;
    bus.en_gear_timer = g;
    if (kind != 3'b000) expQ.push_back('{kind: kind, cycle: cyc + 1 + latency});
  endtask

  task automatic waitPulse(input string tag, input logic [2:0] kind, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ({bus.gear_end, bus.line_end, bus.ready} != 3'b000) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, {29'd0, bus.gear_end, bus.line_end, bus.ready}, {29'd0, kind});
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      p = {bus.gear_end, bus.line_end, bus.ready};
      if (p != 3'b000) begin
        checkOutput("pulse_onehot", {31'd0, $onehot0(p)}, 32'd1);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", {29'd0, p}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_kind", {29'd0, p}, {29'd0, e.kind});
          checkOutput("sb_cycle", cyc, e.cycle);
        end
      end
    end
  end

  initial begin
    int busyCount;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    resetn      = 1'b0;
    bus.acc_len = '0;
    bus.line_len = '0;
    bus.gear_len = '0;
    applyStimulus(0, 0, 0, 3'b000, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset_pulses", {29'd0, bus.gear_end, bus.line_end, bus.ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal accumulate: 3 ticks of 4 -> pulse 13 cycles after entry; length change mid-phase ignored.
    bus.acc_len = 16'd3;
    applyStimulus(1, 0, 0, 3'b001, 3 * P + 1);
    busyCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) bus.acc_len = 16'd1;
      if (bus.busy) busyCount++;
    end
    checkOutput("acc_busy_cycles", busyCount, 13);
    checkOutput("acc_done_busy", {31'd0, bus.busy}, 32'd0);
    applyStimulus(0, 0, 0, 3'b000, 0);
    repeat (3) @(negedge clk);

    // Back-to-back line -> gear.
    bus.line_len = 16'd2;
    bus.gear_len = 16'd1;
    applyStimulus(0, 1, 0, 3'b010, 2 * P + 1);
    waitPulse("line_b2b", 3'b010, 40);
    @(negedge clk);
    applyStimulus(0, 0, 1, 3'b100, 1 * P + 1);
    waitPulse("gear_b2b", 3'b100, 40);
    repeat (4) @(negedge clk);
    applyStimulus(0, 0, 0, 3'b000, 0);
    repeat (3) @(negedge clk);

    // Zero-length gear phase.
    bus.gear_len = 16'd0;
    applyStimulus(0, 0, 1, 3'b100, 1);
    waitPulse("gear_zero", 3'b100, 10);
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 0, 3'b000, 0);
    repeat (3) @(negedge clk);

    // Abort line after 5 of 8 ticks, then restart from zero.
    bus.line_len = 16'd8;
    applyStimulus(0, 1, 0, 3'b000, 0);
    repeat (22) @(negedge clk);
    checkOutput("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    applyStimulus(0, 0, 0, 3'b000, 0);
    @(negedge clk);
    checkOutput("abort_busy_after", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    applyStimulus(0, 1, 0, 3'b010, 8 * P + 1);
    waitPulse("line_restart", 3'b010, 60);
    applyStimulus(0, 0, 0, 3'b000, 0);
    repeat (3) @(negedge clk);

    // Illegal: two enables together -> sticky err, no further pulses.
    applyStimulus(1, 1, 0, 3'b000, 0);
    @(negedge clk);
    checkOutput("multi_err", {31'd0, bus.err}, 32'd1);
    checkOutput("multi_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 1, 3'b000, 0);
    repeat (6) @(negedge clk);
    checkOutput("err_sticky", {31'd0, bus.err}, 32'd1);
    checkOutput("err_busy", {31'd0, bus.busy}, 32'd0);
    applyStimulus(0, 0, 0, 3'b000, 0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", {31'd0, bus.err}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a gear phase.
    bus.gear_len = 16'd3;
    applyStimulus(0, 0, 1, 3'b000, 0);
    repeat (6) @(negedge clk);
    checkOutput("gear_busy", {31'd0, bus.busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("async_pulses", {29'd0, bus.gear_end, bus.line_end, bus.ready}, 32'd0);
    checkOutput("async_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 3'b000, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    checkOutput("missing_pulses", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
